// File: rtl/nonrestore_divider.sv
`default_nettype none
// ============================================================================
// Module      : nonrestore_divider
// Description : Multi-cycle non-restoring divider, 2*WIDTH-bit dividend by
//               WIDTH-bit divisor, valid/ready handshakes on both sides.
//               Define DIVIDER_SIGNED_EN to honour sign_mode (two's complement).
// Revision    : 1.0 - initial release
// ============================================================================
module nonrestore_divider #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  input  logic               sign_mode,
  input  logic               din_valid,
  output logic               din_ready,
  output logic [2*WIDTH-1:0] dout,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero,
  output logic               dout_valid,
  input  logic               dout_ready
);

  localparam int QW = 2 * WIDTH;
  localparam int RW = WIDTH + 2;
  localparam int CW = (QW > 1) ? $clog2(QW) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(QW - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [CW-1:0]    r_cnt;
  logic [QW-1:0]    r_q;
  logic [RW-1:0]    r_rem;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_dvd_lo;
  logic             r_dbz;
  logic [QW-1:0]    r_dout;
  logic [WIDTH-1:0] r_rem_out;
  logic             r_dbz_out;

  logic             w_accept;
  logic             w_consume;
  logic [QW-1:0]    w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [RW-1:0]    w_shift;
  logic [RW-1:0]    w_iter;
  logic [WIDTH-1:0] w_rem_fix;
  logic [QW-1:0]    w_q_out;
  logic [WIDTH-1:0] w_r_out;

  assign din_ready   = (r_state == S_IDLE);
  assign dout_valid  = (r_state == S_DONE);
  assign w_accept    = din_valid & din_ready;
  assign w_consume   = dout_valid & dout_ready;
  assign dout        = r_dout;
  assign remainder   = r_rem_out;
  assign div_by_zero = r_dbz_out;

  // Partial remainder is kept signed in WIDTH+2 bits: |R| < divisor, so 2R+bit fits.
  assign w_shift   = {r_rem[RW-2:0], r_q[QW-1]};
  assign w_iter    = r_rem[RW-1] ? (w_shift + {2'b00, r_dvs}) : (w_shift - {2'b00, r_dvs});
  assign w_rem_fix = r_rem[WIDTH-1:0] + (r_rem[RW-1] ? r_dvs : '0);

`ifdef DIVIDER_SIGNED_EN
  logic w_dvd_neg;
  logic w_dvs_neg;
  logic r_neg_q;
  logic r_neg_r;

  assign w_dvd_neg = sign_mode & dividend[QW-1];
  assign w_dvs_neg = sign_mode & divisor[WIDTH-1];
  assign w_dvd_mag = w_dvd_neg ? -dividend : dividend;
  assign w_dvs_mag = w_dvs_neg ? -divisor : divisor;
  assign w_q_out   = r_neg_q ? -r_q : r_q;
  assign w_r_out   = r_neg_r ? -w_rem_fix : w_rem_fix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_accept) begin
      r_neg_q <= w_dvd_neg ^ w_dvs_neg;
      r_neg_r <= w_dvd_neg;
    end
  end
`else
  logic w_unused_sign;

  assign w_unused_sign = sign_mode;
  assign w_dvd_mag     = dividend;
  assign w_dvs_mag     = divisor;
  assign w_q_out       = r_q;
  assign w_r_out       = w_rem_fix;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = S_CALC;
      S_CALC:  if (r_cnt == C_LAST) w_next_state = S_FIX;
      S_FIX:   w_next_state = S_DONE;
      S_DONE:  if (w_consume) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_q       <= '0;
      r_rem     <= '0;
      r_dvs     <= '0;
      r_dvd_lo  <= '0;
      r_dbz     <= 1'b0;
      r_dout    <= '0;
      r_rem_out <= '0;
      r_dbz_out <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt    <= '0;
            r_q      <= w_dvd_mag;
            r_rem    <= '0;
            r_dvs    <= w_dvs_mag;
            r_dvd_lo <= dividend[WIDTH-1:0];
            r_dbz    <= (divisor == '0);
          end
        end
        S_CALC: begin
          r_q   <= {r_q[QW-2:0], ~w_iter[RW-1]};
          r_rem <= w_iter;
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIX: begin
          r_cnt     <= '0;
          r_dbz_out <= r_dbz;
          // A zero divisor bypasses sign handling and reports the raw dividend low bits.
          if (r_dbz) begin
            r_dout    <= '1;
            r_rem_out <= r_dvd_lo;
          end else begin
            r_dout    <= w_q_out;
            r_rem_out <= w_r_out;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nonrestore_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_nonrestore_divider
// Description : Self-checking bench for nonrestore_divider (WIDTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nonrestore_divider;

  localparam int W  = 4;
  localparam int QW = 2 * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [QW-1:0] dividend = '0;
  logic [W-1:0]  divisor = '0;
  logic          sign_mode = 1'b0;
  logic          din_valid = 1'b0;
  logic          din_ready;
  logic [QW-1:0] dout;
  logic [W-1:0]  remainder;
  logic          div_by_zero;
  logic          dout_valid;
  logic          dout_ready = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  nonrestore_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dividend   (dividend),
    .divisor    (divisor),
    .sign_mode  (sign_mode),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division (SV truncates toward zero, % takes dividend sign).
  function automatic void model(input logic [QW-1:0] a, input logic [W-1:0] b, input logic sm,
                                output logic [QW-1:0] q, output logic [W-1:0] r, output logic z);
    int  sa, sb, iq, ir;
    bit  signed_op;
`ifdef DIVIDER_SIGNED_EN
    signed_op = sm;
`else
    signed_op = 1'b0 & sm;
`endif
    if (b == '0) begin
      q = '1;
      r = a[W-1:0];
      z = 1'b1;
    end else begin
      if (signed_op) begin
        sa = int'($signed(a));
        sb = int'($signed(b));
      end else begin
        sa = int'(a);
        sb = int'(b);
      end
      iq = sa / sb;
      ir = sa % sb;
      q  = iq[QW-1:0];
      r  = ir[W-1:0];
      z  = 1'b0;
    end
  endfunction

  // Called at the falling edge right after the accepting edge.
  task automatic wait_result(input logic [QW-1:0] a, input logic [W-1:0] b, input logic sm,
                             input string tag);
    logic [QW-1:0] eq;
    logic [W-1:0]  er;
    logic          ez;
    int            edges;
    model(a, b, sm, eq, er, ez);
    din_valid = 1'b0;
    dividend  = QW'($urandom);
    divisor   = W'($urandom);
    sign_mode = 1'($urandom);
    edges = 0;
    while (!dout_valid && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      dividend = QW'($urandom);
      divisor  = W'($urandom);
    end
    check({tag, " latency"}, edges, 9);
    check({tag, " dout"}, dout, eq);
    check({tag, " remainder"}, remainder, er);
    check({tag, " div_by_zero"}, div_by_zero, ez);
  endtask

  task automatic consume(input string tag);
    dout_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dout_ready = 1'b0;
    check({tag, " dout_valid cleared"}, dout_valid, 0);
    check({tag, " din_ready after consume"}, din_ready, 1);
  endtask

  task automatic run_op(input logic [QW-1:0] a, input logic [W-1:0] b, input logic sm,
                        input string tag);
    dividend  = a;
    divisor   = b;
    sign_mode = sm;
    din_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wait_result(a, b, sm, tag);
    consume(tag);
  endtask

  initial begin
    bit seen_valid;

    repeat (2) @(negedge clk);
    check("reset din_ready", din_ready, 1);
    check("reset dout", dout, 0);
    check("reset remainder", remainder, 0);
    check("reset div_by_zero", div_by_zero, 0);
    check("reset dout_valid", dout_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(8'd100, 4'd7, 1'b0, "u100/7");
    run_op(8'h9C, 4'd7, 1'b1, "s9C/7");
    run_op(8'h80, 4'hF, 1'b1, "s80/F");
    run_op(8'h80, 4'hF, 1'b0, "u80/F");
    run_op(8'd0, 4'd5, 1'b0, "u0/5");
    run_op(8'd255, 4'd15, 1'b0, "u255/15");
    run_op(8'd255, 4'd1, 1'b0, "u255/1");
    run_op(8'd7, 4'd15, 1'b0, "u7/15");
    run_op(8'h64, 4'h9, 1'b1, "s64/9");
    run_op(8'h9C, 4'h0, 1'b1, "s9C/0");

    // Result held under back-pressure while new operands wait.
    dividend = 8'd100; divisor = 4'd7; sign_mode = 1'b0; din_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wait_result(8'd100, 4'd7, 1'b0, "bp first");
    dividend = 8'd123; divisor = 4'd5; sign_mode = 1'b0; din_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp dout stable", dout, 8'd14);
      check("bp remainder stable", remainder, 4'd2);
      check("bp dout_valid held", dout_valid, 1);
      check("bp din_ready low", din_ready, 0);
    end
    dout_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dout_ready = 1'b0;
    check("bp consumed", dout_valid, 0);
    check("bp din_ready after consume", din_ready, 1);
    @(posedge clk);
    @(negedge clk);
    wait_result(8'd123, 4'd5, 1'b0, "bp second");
    consume("bp second");

    run_op(8'd200, 4'd0, 1'b0, "u200/0");

    // Reset in the middle of an operation aborts it.
    dividend = 8'd200; divisor = 4'd9; sign_mode = 1'b0; din_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    din_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort dout", dout, 0);
    check("abort remainder", remainder, 0);
    check("abort div_by_zero", div_by_zero, 0);
    check("abort dout_valid", dout_valid, 0);
    check("abort din_ready", din_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (dout_valid) seen_valid = 1'b1;
    end
    check("abort no result", seen_valid, 0);
    run_op(8'd100, 4'd7, 1'b0, "post-abort 100/7");

    for (int i = 0; i < 30; i++) begin
      run_op(QW'($urandom), W'($urandom), 1'($urandom), $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nonrestore_divider.md
NONRESTORE_DIVIDER -- requirements
Module: nonrestore_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 4: divisor and remainder width; dividend and quotient are 2*WIDTH bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port dividend  input  2*WIDTH  numerator, sampled on input handshake.
REQ-005 SHALL have port divisor  input  WIDTH  denominator, sampled on input handshake.
REQ-006 SHALL have port sign_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled on input handshake.
REQ-007 SHALL have port din_valid  input  1  operands valid.
REQ-008 SHALL have port din_ready  output  1  block can accept operands.
REQ-009 SHALL have port dout  output  2*WIDTH  quotient.
REQ-010 SHALL have port remainder  output  WIDTH  remainder.
REQ-011 SHALL have port div_by_zero  output  1  divisor was zero for this result.
REQ-012 SHALL have port dout_valid  output  1  result valid.
REQ-013 SHALL have port dout_ready  input  1  consumer accepts result.

Function
REQ-014 SHALL implement FSM IDLE -> CALC -> FIX -> DONE -> IDLE.
REQ-015 din_ready SHALL be 1 only in IDLE; input handshake = din_valid & din_ready at a rising edge, moving IDLE -> CALC.
REQ-016 CALC SHALL last exactly 2*WIDTH cycles, one non-restoring quotient bit per cycle (add or subtract by sign of partial remainder), iteration counter counting 0..2*WIDTH-1.
REQ-017 FIX SHALL last one cycle: remainder correction (add divisor if partial remainder negative) and signed result fix-up.
REQ-018 dout_valid SHALL rise at the edge 2*WIDTH+1 edges after the accepting edge (WIDTH=4: 9 edges).
REQ-019 In DONE, dout, remainder, div_by_zero SHALL be held stable with dout_valid=1 until dout_valid & dout_ready; then -> IDLE, din_ready=1 the next cycle.
REQ-020 No new operand SHALL be accepted in the cycle the result is consumed.
REQ-021 Unsigned: dout = floor(dividend/divisor), remainder = dividend mod divisor.
REQ-022 Signed: operands take magnitude internally; quotient truncates toward zero; quotient negative iff operand signs differ; remainder carries dividend sign.
REQ-023 Signed overflow (dividend = -2^(2*WIDTH-1), divisor = -1) SHALL give dout = 2^(2*WIDTH-1) wrapped (bit pattern 100..0), remainder 0, div_by_zero 0.
REQ-024 divisor = 0 SHALL give dout all ones, remainder = dividend[WIDTH-1:0], div_by_zero=1, same latency, any sign_mode.
REQ-025 Input changes outside the handshake SHALL not affect an operation in progress.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, din_ready=1, dout=0, remainder=0, div_by_zero=0, dout_valid=0, counter=0.
REQ-027 Reset during CALC, FIX or DONE SHALL abort the operation with no result produced; first acceptance is possible at the first edge after rst_n rises.

Configuration
REQ-028 Macro DIVIDER_SIGNED_EN defined: sign_mode honoured per REQ-022/023.
REQ-029 DIVIDER_SIGNED_EN undefined: sign_mode port present but ignored, all operations unsigned, no sign fix-up logic; latency unchanged.

Verification (WIDTH=4)
REQ-030 Unsigned 100/7, sign_mode=0, dout_ready=1 -> dout=14, remainder=2, div_by_zero=0, dout_valid 9 edges after acceptance.
REQ-031 200/0 -> dout=255, remainder=8, div_by_zero=1, same latency.
REQ-032 DIVIDER_SIGNED_EN defined, sign_mode=1, dividend 0x9C (-100), divisor 7 -> dout=0xF2 (-14), remainder=0xE (-2); 0x80 / 0xF -> dout=0x80, remainder=0.
REQ-033 DIVIDER_SIGNED_EN undefined, sign_mode=1, 0x9C/7 -> dout=22, remainder=2.
REQ-034 Result ready, dout_ready held 0 for 5 cycles while din_valid=1 with new operands -> outputs stable, din_ready=0, no acceptance; consumed at cycle 6, new operands accepted the following cycle.
REQ-035 rst_n pulsed low mid-CALC -> all outputs zero, din_ready=1, no dout_valid for the aborted operation; next operation 100/7 -> 14 r 2.
